audio_peak_meter: RTL
=====================

# audio_peak_meter

Windowed peak-level detector for the AGC audio path. Consumes the signed PCM sample stream, tracks the largest magnitude over a fixed window of valid samples, and publishes a held 10-bit level word plus a clip flag. The level word drives the 10-bit input port the Nios II polls, so software always reads a stable, once-per-window measurement.

## Interface
- SAMPLE_W, 16: width of signed two's-complement input samples.
- LEVEL_W, 10: width of published level; must be ≤ SAMPLE_W-1.
- WINDOW, 1024: valid samples per measurement window; ≥ 2.
- CLIP_THRESH, 32767: magnitude at or above which a sample counts as clipped.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous window restart; does not touch published outputs.
- sample_valid  in  1  qualifies sample_data for one cycle.
- sample_data  in  SAMPLE_W  signed PCM sample.
- level  out  LEVEL_W  held peak level of the last completed window; connects to the PIO in_port.
- clip  out  1  held; 1 if any sample in the last completed window reached CLIP_THRESH.
- level_update  out  1  one-cycle pulse when level/clip load a new value.

## Operation
- Magnitude: mag = |sample_data|, SAMPLE_W-1 bits unsigned; most-negative input (-2^(SAMPLE_W-1)) saturates to 2^(SAMPLE_W-1)-1.
- Internal state: peak (SAMPLE_W-1 bits), clip_acc (1 bit), cnt (clog2(WINDOW) bits, 0..WINDOW-1).
- On each sample_valid cycle not on the last window sample: peak <= max(peak, mag); clip_acc <= clip_acc | (mag ≥ CLIP_THRESH); cnt <= cnt+1.
- Window close (sample_valid && cnt == WINDOW-1): level <= top LEVEL_W bits of max(peak, mag), i.e. bits [SAMPLE_W-2 : SAMPLE_W-1-LEVEL_W]; clip <= clip_acc | (mag ≥ CLIP_THRESH); level_update <= 1; peak <= 0; clip_acc <= 0; cnt <= 0. The closing sample belongs to the closing window.
- No sample_valid: peak, clip_acc, cnt hold; level_update <= 0.
- clear: peak <= 0, clip_acc <= 0, cnt <= 0; the sample in the same cycle is discarded; level/clip hold; no level_update. clear has priority over sample_valid and over window close.
- Two-state view: ACCUM (cnt < WINDOW-1) and CLOSE (cnt == WINDOW-1, awaiting the last sample); CLOSE -> ACCUM only on the valid sample or clear.
- Truncation only, no rounding; level never wraps.

## Timing
- Reset values: level = 0, clip = 0, level_update = 0, peak = 0, clip_acc = 0, cnt = 0.
- Latency: level/clip/level_update change on the clock edge following the rising edge that samples the window-closing valid input (1 cycle).
- level and clip are stable for at least WINDOW valid samples between updates; no glitches between updates.
- Back-to-back sample_valid on every cycle supported; minimum update spacing = WINDOW cycles.
- reset mid-window: the partial window is discarded and all outputs return to reset values on the next edge; the first window after reset starts at cnt = 0.
- sample_data is ignored when sample_valid = 0.

## Test plan
- Reset, then WINDOW=1024 valid samples all +1000 -> one level_update pulse 1 cycle after the 1024th sample; level = 1000>>5 = 31; clip = 0.
- Window with a single -32768 as sample 500, the rest 0 -> level = 1023, clip = 1; the next window of zeros -> level = 0, clip = 0.
- Peak only on the closing (1024th) sample = +16384, others 100 -> level = 512 (the closing sample counts).
- Valid asserted every 3rd cycle, 1024 samples of +320 -> exactly one update; level = 10, stable across all idle cycles.
- clear asserted at sample 700 carrying +30000, then 1024 samples of +64 -> the +30000 sample is excluded; the update occurs after 1024 post-clear samples; level = 2; prior level holds until then.
- reset asserted at sample 300 of a window of +8000 -> level = 0, clip = 0 next cycle; the subsequent full window of +8000 -> level = 250.

Source files
------------

// File: rtl/audio_peak_meter.sv
// Windowed peak-level detector: tracks the largest sample magnitude over a
// fixed count of valid samples and publishes a held level word and clip flag
// once per window, with a one-cycle update pulse.
module audio_peak_meter #(
  parameter int unsigned SAMPLE_W    = 16,
  parameter int unsigned LEVEL_W     = 10,
  parameter int unsigned WINDOW      = 1024,
  parameter int unsigned CLIP_THRESH = 32767
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic [LEVEL_W-1:0]  level,
  output logic                clip,
  output logic                level_update
);

  localparam int unsigned CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0]    CNT_PRE  = CNT_W'(WINDOW - 2);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [SAMPLE_W-2:0] MAG_ONE  = (SAMPLE_W-1)'(1);
  localparam logic [SAMPLE_W-2:0] CLIP_T   = (SAMPLE_W-1)'(CLIP_THRESH);

  typedef enum logic {
    ST_ACCUM,
    ST_CLOSE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [SAMPLE_W-2:0] r_peak;
  logic                r_clip_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [LEVEL_W-1:0]  r_level;
  logic                r_clip;
  logic                r_level_update;

  logic                w_neg;
  logic                w_most_neg;
  logic [SAMPLE_W-2:0] w_neg_mag;
  logic [SAMPLE_W-2:0] w_mag;
  logic [SAMPLE_W-2:0] w_max;
  logic                w_over;
  logic                w_close;

  // Magnitude only needs the low bits of the negation; the most-negative
  // code negates to zero there, so it is saturated explicitly.
  assign w_neg      = sample_data[SAMPLE_W-1];
  assign w_most_neg = w_neg && (sample_data[SAMPLE_W-2:0] == '0);
  assign w_neg_mag  = ~sample_data[SAMPLE_W-2:0] + MAG_ONE;
  assign w_mag      = !w_neg     ? sample_data[SAMPLE_W-2:0] :
                      w_most_neg ? '1 : w_neg_mag;
  assign w_max      = (w_mag > r_peak) ? w_mag : r_peak;
  assign w_over     = (w_mag >= CLIP_T);
  assign w_close    = (r_state == ST_CLOSE) && sample_valid && !clear;

  // State register: ACCUM while collecting, CLOSE when waiting for the last sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: CLOSE is entered on the second-to-last sample, left on the last or on clear.
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = ST_ACCUM;
    end else if (sample_valid) begin
      case (r_state)
        ST_ACCUM: if (r_cnt == CNT_PRE) w_state_next = ST_CLOSE;
        ST_CLOSE: w_state_next = ST_ACCUM;
        default:  w_state_next = ST_ACCUM;
      endcase
    end
  end

  // Window accumulation and publication of the held outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_peak         <= '0;
      r_clip_acc     <= 1'b0;
      r_cnt          <= '0;
      r_level        <= '0;
      r_clip         <= 1'b0;
      r_level_update <= 1'b0;
    end else begin
      r_level_update <= 1'b0;
      if (clear) begin
        r_peak     <= '0;
        r_clip_acc <= 1'b0;
        r_cnt      <= '0;
      end else if (w_close) begin
        r_level        <= w_max[SAMPLE_W-2 -: LEVEL_W];
        r_clip         <= r_clip_acc | w_over;
        r_level_update <= 1'b1;
        r_peak         <= '0;
        r_clip_acc     <= 1'b0;
        r_cnt          <= '0;
      end else if (sample_valid) begin
        r_peak     <= w_max;
        r_clip_acc <= r_clip_acc | w_over;
        r_cnt      <= r_cnt + CNT_ONE;
      end
    end
  end

  assign level        = r_level;
  assign clip         = r_clip;
  assign level_update = r_level_update;

endmodule
